// File: rtl/rc_frame_scheduler.sv
// RC receiver frame scheduler: gathers per-channel pulse captures into a clamped
// frame, publishes it with a valid/ready handshake and flags link loss on timeout.
module rc_frame_scheduler #(
  parameter int NUM_CH      = 6,
  parameter int W           = 16,
  parameter int MIN_W       = 900,
  parameter int MAX_W       = 2100,
  parameter int TIMEOUT_CYC = 2500000
) (
  input  logic                S_AXI_ACLK,
  input  logic                S_AXI_ARESETN,
  input  logic [NUM_CH-1:0]   cap_valid,
  input  logic [NUM_CH*W-1:0] cap_width,
  output logic                frame_valid,
  input  logic                frame_ready,
  output logic [NUM_CH*W-1:0] frame_data,
  output logic [NUM_CH-1:0]   frame_err,
  output logic                failsafe,
  output logic [15:0]         frame_cnt
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [W-1:0]  MIN_L   = W'(MIN_W);
  localparam logic [W-1:0]  MAX_L   = W'(MAX_W);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    PUBLISH  = 2'd2,
    FAILSAFE = 2'd3
  } state_t;

  state_t              state_r, state_next_s;
  logic [NUM_CH*W-1:0] shadow_r, merged_s;
  logic [NUM_CH-1:0]   shadow_err_r, merged_err_s;
  logic [NUM_CH-1:0]   seen_r, seen_next_s;
  logic [CW-1:0]       cnt_r;
  logic                complete_s, timeout_s, handshake_s;
  logic                load_frame_s, seen_clr_s, cnt_clr_s, fs_set_s, fs_clr_s;

  function automatic logic [W-1:0] clamp_w(input logic [W-1:0] v);
    if (v < MIN_L) begin
      return MIN_L;
    end else if (v > MAX_L) begin
      return MAX_L;
    end else begin
      return v;
    end
  endfunction

  function automatic logic out_of_range(input logic [W-1:0] v);
    return (v < MIN_L) || (v > MAX_L);
  endfunction

  // Shadow view including this cycle's captures, so a completing capture is published.
  always_comb begin
    merged_s     = shadow_r;
    merged_err_s = shadow_err_r;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cap_valid[i]) begin
        merged_s[i*W +: W] = clamp_w(cap_width[i*W +: W]);
        merged_err_s[i]    = out_of_range(cap_width[i*W +: W]);
      end else begin
        merged_s[i*W +: W] = shadow_r[i*W +: W];
        merged_err_s[i]    = shadow_err_r[i];
      end
    end
  end

  assign seen_next_s = seen_r | cap_valid;
  assign complete_s  = &seen_next_s;
  assign timeout_s   = (cnt_r == TO_LAST);
  assign handshake_s = (state_r == PUBLISH) && frame_valid && frame_ready;

  // State register.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; frame completion wins over a coincident timeout.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (complete_s) begin
          state_next_s = PUBLISH;
        end else if (|cap_valid) begin
          state_next_s = COLLECT;
        end else begin
          state_next_s = IDLE;
        end
      end
      COLLECT, FAILSAFE: begin
        if (complete_s) begin
          state_next_s = PUBLISH;
        end else if (timeout_s) begin
          state_next_s = FAILSAFE;
        end else begin
          state_next_s = state_r;
        end
      end
      PUBLISH: begin
        if (handshake_s) begin
          state_next_s = (seen_next_s != {NUM_CH{1'b0}}) ? COLLECT : IDLE;
        end else begin
          state_next_s = PUBLISH;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Per-state control strobes for the datapath registers.
  always_comb begin
    load_frame_s = 1'b0;
    seen_clr_s   = 1'b0;
    cnt_clr_s    = 1'b0;
    fs_set_s     = 1'b0;
    fs_clr_s     = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_clr_s = 1'b1;
        if (complete_s) begin
          load_frame_s = 1'b1;
          seen_clr_s   = 1'b1;
        end else begin
          load_frame_s = 1'b0;
        end
      end
      COLLECT, FAILSAFE: begin
        if (complete_s) begin
          load_frame_s = 1'b1;
          seen_clr_s   = 1'b1;
          cnt_clr_s    = 1'b1;
        end else if (timeout_s) begin
          fs_set_s   = 1'b1;
          seen_clr_s = 1'b1;
          cnt_clr_s  = 1'b1;
        end else begin
          cnt_clr_s = 1'b0;
        end
      end
      PUBLISH: begin
        // A timeout here only restarts the counter; the pending frame stays valid.
        if (handshake_s) begin
          fs_clr_s  = 1'b1;
          cnt_clr_s = 1'b1;
        end else if (timeout_s) begin
          cnt_clr_s = 1'b1;
        end else begin
          cnt_clr_s = 1'b0;
        end
      end
      default: begin
        seen_clr_s = 1'b1;
        cnt_clr_s  = 1'b1;
      end
    endcase
  end

  // Shadow, seen mask, timeout counter and registered frame outputs.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      shadow_r     <= {(NUM_CH*W){1'b0}};
      shadow_err_r <= {NUM_CH{1'b0}};
      seen_r       <= {NUM_CH{1'b0}};
      cnt_r        <= {CW{1'b0}};
      frame_valid  <= 1'b0;
      frame_data   <= {(NUM_CH*W){1'b0}};
      frame_err    <= {NUM_CH{1'b0}};
      failsafe     <= 1'b0;
      frame_cnt    <= 16'd0;
    end else begin
      shadow_r     <= merged_s;
      shadow_err_r <= merged_err_s;
      seen_r       <= seen_clr_s ? {NUM_CH{1'b0}} : seen_next_s;
      cnt_r        <= cnt_clr_s ? {CW{1'b0}} : cnt_r + CW'(1);
      if (load_frame_s) begin
        frame_valid <= 1'b1;
        frame_data  <= merged_s;
        frame_err   <= merged_err_s;
      end else if (handshake_s) begin
        frame_valid <= 1'b0;
        frame_cnt   <= frame_cnt + 16'd1;
      end else begin
        frame_valid <= frame_valid;
      end
      if (fs_set_s) begin
        failsafe <= 1'b1;
      end else if (fs_clr_s) begin
        failsafe <= 1'b0;
      end else begin
        failsafe <= failsafe;
      end
    end
  end

endmodule

// File: tb/tb_rc_frame_scheduler.sv
// Self-checking bench for rc_frame_scheduler: expected frames are queued when
// captures are driven and compared by a monitor at each handshake.
module tb_rc_frame_scheduler;

  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  cap_valid;
  logic [95:0] cap_width;
  logic        frame_valid;
  logic        frame_ready;
  logic [95:0] frame_data;
  logic [5:0]  frame_err;
  logic        failsafe;
  logic [15:0] frame_cnt;

  int           n_checks = 0;
  int           n_err    = 0;
  int           exp_cnt  = 0;
  int           fv[6];
  logic [101:0] sb_q[$];
  logic [101:0] exp_a;

  always #5 clk = ~clk;

  rc_frame_scheduler #(
    .NUM_CH(6), .W(16), .MIN_W(900), .MAX_W(2100), .TIMEOUT_CYC(TO)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(rst_n),
    .cap_valid    (cap_valid),
    .cap_width    (cap_width),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .frame_data   (frame_data),
    .frame_err    (frame_err),
    .failsafe     (failsafe),
    .frame_cnt    (frame_cnt)
  );

  function automatic logic [101:0] model_frame();
    logic [95:0] d;
    logic [5:0]  e;
    for (int i = 0; i < 6; i++) begin
      if (fv[i] < 900) begin
        d[i*16 +: 16] = 16'd900;  e[i] = 1'b1;
      end else if (fv[i] > 2100) begin
        d[i*16 +: 16] = 16'd2100; e[i] = 1'b1;
      end else begin
        d[i*16 +: 16] = 16'(fv[i]); e[i] = 1'b0;
      end
    end
    return {e, d};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic cap_one(input int ch, input int val);
    cap_valid = 6'd0;
    cap_valid[ch] = 1'b1;
    cap_width[ch*16 +: 16] = 16'(val);
    step();
    cap_valid = 6'd0;
  endtask

  task automatic send_frame();
    for (int ch = 0; ch < 6; ch++) cap_one(ch, fv[ch]);
  endtask

  // Scoreboard monitor: a handshake happens at the next edge when valid && ready now.
  always begin : monitor
    logic [101:0] exp_f;
    @(negedge clk);
    #1;
    if (rst_n === 1'b1 && frame_valid === 1'b1 && frame_ready === 1'b1) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_empty: handshake data=%h err=%b but no frame expected", frame_data, frame_err);
      end else begin
        exp_f = sb_q.pop_front();
        if ({frame_err, frame_data} !== exp_f) begin
          n_err++;
          $display("FAIL sb_frame: got err=%b data=%h expected err=%b data=%h",
                   frame_err, frame_data, exp_f[101:96], exp_f[95:0]);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; cap_valid = 6'd0; cap_width = 96'd0; frame_ready = 1'b0;
    repeat (3) step();
    n_checks++; if (frame_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", frame_valid); end
    n_checks++; if (frame_data !== 96'd0) begin n_err++; $display("FAIL rst_data: got %h want 0", frame_data); end
    n_checks++; if (frame_err !== 6'd0) begin n_err++; $display("FAIL rst_err: got %b want 0", frame_err); end
    n_checks++; if (failsafe !== 1'b0) begin n_err++; $display("FAIL rst_failsafe: got %b want 0", failsafe); end
    n_checks++; if (frame_cnt !== 16'd0) begin n_err++; $display("FAIL rst_cnt: got %0d want 0", frame_cnt); end
    rst_n = 1'b1;
    step();
    n_checks++; if (frame_valid !== 1'b0) begin n_err++; $display("FAIL rst_release: valid=%b want 0", frame_valid); end
  endtask

  task automatic test_nominal();
    fv = '{1000, 1100, 1200, 1300, 1400, 1500};
    sb_q.push_back(model_frame());
    frame_ready = 1'b1;
    for (int ch = 0; ch < 5; ch++) cap_one(ch, fv[ch]);
    n_checks++; if (frame_valid !== 1'b0) begin n_err++; $display("FAIL nom_early: valid=%b want 0", frame_valid); end
    cap_one(5, fv[5]);
    n_checks++; if (frame_valid !== 1'b1) begin n_err++; $display("FAIL nom_latency: valid=%b want 1", frame_valid); end
    n_checks++; if (frame_err !== 6'd0) begin n_err++; $display("FAIL nom_err: got %b want 000000", frame_err); end
    step();
    exp_cnt++;
    n_checks++; if (frame_valid !== 1'b0) begin n_err++; $display("FAIL nom_drop: valid=%b want 0", frame_valid); end
    n_checks++; if (frame_cnt !== 16'(exp_cnt)) begin n_err++; $display("FAIL nom_cnt: got %0d want %0d", frame_cnt, exp_cnt); end
    frame_ready = 1'b0;
  endtask

  task automatic test_clamp();
    fv = '{1500, 1500, 700, 1500, 2500, 1500};
    sb_q.push_back(model_frame());
    frame_ready = 1'b1;
    send_frame();
    n_checks++; if (frame_err !== 6'b010100) begin n_err++; $display("FAIL clamp_err: got %b want 010100", frame_err); end
    n_checks++; if (frame_data[32 +: 16] !== 16'd900) begin n_err++; $display("FAIL clamp_lo: got %0d want 900", frame_data[32 +: 16]); end
    n_checks++; if (frame_data[64 +: 16] !== 16'd2100) begin n_err++; $display("FAIL clamp_hi: got %0d want 2100", frame_data[64 +: 16]); end
    step();
    exp_cnt++;
    // Exact limits are legal; one past either limit is flagged.
    fv = '{899, 900, 2100, 2101, 0, 65535};
    sb_q.push_back(model_frame());
    send_frame();
    n_checks++; if (frame_err !== 6'b111001) begin n_err++; $display("FAIL clamp_edges: got %b want 111001", frame_err); end
    step();
    exp_cnt++;
    n_checks++; if (frame_cnt !== 16'(exp_cnt)) begin n_err++; $display("FAIL clamp_cnt: got %0d want %0d", frame_cnt, exp_cnt); end
    frame_ready = 1'b0;
  endtask

  task automatic test_timeout();
    frame_ready = 1'b0;
    for (int ch = 0; ch < 5; ch++) cap_one(ch, 1234);
    repeat (TO - 5) step();
    n_checks++; if (failsafe !== 1'b0) begin n_err++; $display("FAIL to_early: failsafe=%b want 0 at cycle %0d", failsafe, TO - 1); end
    step();
    n_checks++; if (failsafe !== 1'b1) begin n_err++; $display("FAIL to_fire: failsafe=%b want 1 at cycle %0d", failsafe, TO); end
    cap_one(5, 1234);
    n_checks++; if (frame_valid !== 1'b0) begin n_err++; $display("FAIL to_seen_clr: valid=%b want 0", frame_valid); end
    repeat (TO - 1) step();
    n_checks++; if (failsafe !== 1'b1) begin n_err++; $display("FAIL to_hold: failsafe=%b want 1", failsafe); end
    fv = '{1010, 1020, 1030, 1040, 1050, 1060};
    sb_q.push_back(model_frame());
    frame_ready = 1'b1;
    send_frame();
    n_checks++; if (frame_valid !== 1'b1) begin n_err++; $display("FAIL to_recover: valid=%b want 1", frame_valid); end
    step();
    exp_cnt++;
    n_checks++; if (failsafe !== 1'b0) begin n_err++; $display("FAIL to_clear: failsafe=%b want 0", failsafe); end
    n_checks++; if (frame_cnt !== 16'(exp_cnt)) begin n_err++; $display("FAIL to_cnt: got %0d want %0d", frame_cnt, exp_cnt); end
    frame_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic hold_ok;
    frame_ready = 1'b0;
    fv = '{1100, 1200, 1300, 1400, 1500, 1600};
    exp_a = model_frame();
    sb_q.push_back(exp_a);
    send_frame();
    fv = '{2000, 1900, 1800, 1700, 1600, 950};
    sb_q.push_back(model_frame());
    hold_ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (frame_valid !== 1'b1 || frame_data !== exp_a[95:0] || frame_err !== exp_a[101:96]) hold_ok = 1'b0;
      if (i < 6) cap_one(i, fv[i]);
      else step();
    end
    n_checks++; if (hold_ok !== 1'b1) begin n_err++; $display("FAIL bp_hold: frame changed or dropped, data=%h want %h", frame_data, exp_a[95:0]); end
    frame_ready = 1'b1;
    step();
    exp_cnt++;
    n_checks++; if (frame_valid !== 1'b0) begin n_err++; $display("FAIL bp_drop: valid=%b want 0", frame_valid); end
    n_checks++; if (frame_cnt !== 16'(exp_cnt)) begin n_err++; $display("FAIL bp_cnt: got %0d want %0d", frame_cnt, exp_cnt); end
    step();
    n_checks++; if (frame_valid !== 1'b1) begin n_err++; $display("FAIL bp_next: valid=%b want 1", frame_valid); end
    step();
    exp_cnt++;
    n_checks++; if (frame_cnt !== 16'(exp_cnt)) begin n_err++; $display("FAIL bp_cnt2: got %0d want %0d", frame_cnt, exp_cnt); end
    frame_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    fv = '{1111, 1222, 1333, 1444, 1555, 1666};
    sb_q.push_back(model_frame());
    for (int ch = 0; ch < 6; ch++) cap_width[ch*16 +: 16] = 16'(fv[ch]);
    cap_valid = 6'h3F;
    step();
    cap_valid = 6'd0;
    n_checks++; if (frame_valid !== 1'b1) begin n_err++; $display("FAIL sim_pub: valid=%b want 1", frame_valid); end
    frame_ready = 1'b1;
    step();
    exp_cnt++;
    fv = '{1800, 1200, 1300, 1400, 1500, 1600};
    sb_q.push_back(model_frame());
    cap_one(0, 1000);
    for (int ch = 1; ch < 5; ch++) cap_one(ch, fv[ch]);
    cap_one(0, 1800);
    n_checks++; if (frame_valid !== 1'b0) begin n_err++; $display("FAIL ovr_early: valid=%b want 0", frame_valid); end
    cap_one(5, fv[5]);
    n_checks++; if (frame_data[15:0] !== 16'd1800) begin n_err++; $display("FAIL ovr_ch0: got %0d want 1800", frame_data[15:0]); end
    step();
    exp_cnt++;
    n_checks++; if (frame_cnt !== 16'(exp_cnt)) begin n_err++; $display("FAIL ovr_cnt: got %0d want %0d", frame_cnt, exp_cnt); end
    frame_ready = 1'b0;
  endtask

  task automatic test_reset_publish();
    fv = '{1300, 1300, 1300, 1300, 1300, 1300};
    send_frame();
    n_checks++; if (frame_valid !== 1'b1) begin n_err++; $display("FAIL rp_pending: valid=%b want 1", frame_valid); end
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    n_checks++; if (frame_valid !== 1'b0) begin n_err++; $display("FAIL rp_valid: got %b want 0", frame_valid); end
    n_checks++; if (frame_cnt !== 16'd0) begin n_err++; $display("FAIL rp_cnt: got %0d want 0", frame_cnt); end
    n_checks++; if (frame_data !== 96'd0) begin n_err++; $display("FAIL rp_data: got %h want 0", frame_data); end
    step();
    rst_n = 1'b1;
    frame_ready = 1'b1;
    repeat (3) step();
    n_checks++; if (frame_valid !== 1'b0) begin n_err++; $display("FAIL rp_idle: valid=%b want 0", frame_valid); end
    fv = '{1400, 1500, 1600, 1700, 1800, 1900};
    sb_q.push_back(model_frame());
    send_frame();
    step();
    exp_cnt++;
    n_checks++; if (frame_cnt !== 16'(exp_cnt)) begin n_err++; $display("FAIL rp_after: cnt=%0d want %0d", frame_cnt, exp_cnt); end
    frame_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_clamp();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_publish();
    step();
    n_checks++; if (sb_q.size() != 0) begin n_err++; $display("FAIL sb_left: %0d frames never published, want 0", sb_q.size()); end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/rc_frame_scheduler.md
RC_FRAME_SCHEDULER -- requirements
Module: rc_frame_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 6: number of receiver channels.
REQ-002 SHALL have parameter W, default 16: pulse-width field width, in 1 us ticks.
REQ-003 SHALL have parameter MIN_W, default 900: lowest legal pulse width.
REQ-004 SHALL have parameter MAX_W, default 2100: highest legal pulse width.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 2500000: frame timeout in clocks (25 ms at 100 MHz).
REQ-006 SHALL have port S_AXI_ACLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port S_AXI_ARESETN, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port cap_valid, input, NUM_CH bits: one-cycle capture-done pulse per channel.
REQ-009 SHALL have port cap_width, input, NUM_CH*W bits: measured widths; channel i is in bits [i*W +: W].
REQ-010 SHALL have port frame_valid, output, 1 bit: published frame available.
REQ-011 SHALL have port frame_ready, input, 1 bit: consumer (AXI register bank) accepts the frame.
REQ-012 SHALL have port frame_data, output, NUM_CH*W bits: published clamped widths, same packing as cap_width.
REQ-013 SHALL have port frame_err, output, NUM_CH bits: per-channel out-of-range flag for the published frame.
REQ-014 SHALL have port failsafe, output, 1 bit: high while link is considered lost.
REQ-015 SHALL have port frame_cnt, output, 16 bits: count of accepted frames.

Function
REQ-016 SHALL implement states IDLE, COLLECT, PUBLISH and FAILSAFE, each encoded explicitly.
REQ-017 SHALL hold an internal shadow width register per channel and a NUM_CH-bit seen mask.
REQ-018 SHALL, on cap_valid[i] in any state, load shadow[i] and set seen[i]; a repeat capture overwrites (last wins).
REQ-019 SHALL, on cap_valid[i], clamp the width to [MIN_W, MAX_W] and record err[i] = 1 if the raw width was outside that range.
REQ-020 SHALL move IDLE to COLLECT on any cap_valid bit, clearing the timeout counter.
REQ-021 SHALL, in COLLECT or FAILSAFE, compute seen_next = seen | cap_valid; when seen_next is all ones, it SHALL load frame_data and frame_err from the merged shadow (including same-cycle captures), clear seen, and enter PUBLISH; frame_valid SHALL rise the cycle after the final cap_valid.
REQ-022 SHALL, in COLLECT, increment the timeout counter every cycle; if it reaches TIMEOUT_CYC-1 without completing a frame, it SHALL enter FAILSAFE, set failsafe = 1, clear seen and clear the counter.
REQ-023 SHALL, in FAILSAFE, collect exactly as in COLLECT; the counter SHALL keep restarting at each timeout and failsafe SHALL stay 1.
REQ-024 SHALL, in PUBLISH, hold frame_valid = 1 with frame_data and frame_err stable until the cycle in which frame_valid and frame_ready are both 1.
REQ-025 SHALL, in PUBLISH, keep collecting captures into shadow and seen; the PUBLISH timeout counter SHALL run, but a timeout SHALL NOT drop frame_valid.
REQ-026 SHALL, on the PUBLISH handshake, drop frame_valid the next cycle, increment frame_cnt (wrapping 0xFFFF to 0), clear failsafe, and go to COLLECT (counter cleared) if seen != 0, else to IDLE.
REQ-027 SHALL ignore frame_ready while frame_valid = 0.
REQ-028 SHALL, if a timeout occurs in the same cycle that a frame completes, give priority to the completion.

Reset
REQ-029 SHALL, while S_AXI_ARESETN = 0, immediately force state = IDLE, seen = 0, all shadow = 0, timeout counter = 0, frame_valid = 0, frame_data = 0, frame_err = 0, failsafe = 0 and frame_cnt = 0.
REQ-030 SHALL, if reset is asserted mid-COLLECT or mid-PUBLISH, discard the partial or pending frame; the first cycle after release SHALL be IDLE.

Verification
REQ-031 SHALL cover the nominal frame: pulse channels 0..5 with widths 1000, 1100, 1200, 1300, 1400, 1500, one per cycle, frame_ready = 1 -> frame_valid high 1 cycle after channel 5, frame_data matches, frame_err = 0, frame_cnt = 1.
REQ-032 SHALL cover clamping: channel 2 = 700 and channel 4 = 2500, others 1500 -> frame_data ch2 = 900, ch4 = 2100, frame_err = 6'b010100.
REQ-033 SHALL cover timeout: TIMEOUT_CYC = 100, pulse channels 0..4 only -> failsafe = 1 at cycle 100 after the first capture; a later full frame plus handshake -> failsafe = 0, frame_cnt += 1.
REQ-034 SHALL cover backpressure: frame_ready = 0 for 50 cycles while all 6 channels re-capture with new values -> frame_data unchanged until the handshake; after the handshake the state is COLLECT and the next frame publishes immediately with the new values.
REQ-035 SHALL cover simultaneous and overwrite cases: all 6 cap_valid in one cycle -> PUBLISH next cycle; channel 0 captured twice (1000 then 1800) before completion -> published ch0 = 1800.
REQ-036 SHALL cover reset during PUBLISH: assert S_AXI_ARESETN = 0 while frame_valid = 1 -> frame_valid = 0 and frame_cnt = 0 immediately, with no handshake counted.
